// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - cycle, retire and event counters for cpu_pipelined with watchdog and registered read port.
// Optional PERF_EXEC_TIME_EN builds the execution-time register (cycles * CLK_PERIOD_PS).
module perf_monitor #(
  parameter int NUM_EVENTS    = 4,
  parameter int CNT_WIDTH     = 64,
  parameter int MAX_CYCLES    = 0,
  parameter int CLK_PERIOD_PS = 10000,
  parameter int SEL_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  end_program,
  input  logic                  retire,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  running,
  output logic                  done,
  output logic                  timeout,
  output logic [NUM_EVENTS+1:0] ovf
);

  localparam int NUM_CNT = NUM_EVENTS + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(MAX_CYCLES);

  if ((1 << SEL_W) < NUM_EVENTS + 3 || CLK_PERIOD_PS <= 0) begin : g_bad_params
    $error("perf_monitor: invalid parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t state_q, state_d;
  logic   zero_cnt;
  logic   count_en;
  logic   wd_hit;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cyc_next;
  logic [NUM_CNT-1:0]   inc;
  logic [CNT_WIDTH-1:0] exec_time;
  logic [CNT_WIDTH-1:0] rd_next;

  // Slot 0 counts every RUN cycle; slot 1 retires; slots 2.. are the generic events.
  assign inc      = {event_in, retire, 1'b1};
  assign cyc_next = (&cnt_q[0]) ? cnt_q[0] : cnt_q[0] + CNT_ONE;
  assign wd_hit   = (MAX_CYCLES != 0) && (cyc_next == WD_LIMIT);

  always_comb begin
    state_d  = state_q;
    zero_cnt = 1'b0;
    count_en = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      zero_cnt = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            zero_cnt = 1'b1;
          end
        end
        S_RUN: begin
          count_en = 1'b1;
          if (end_program) begin
            state_d = S_DONE;
          end else if (wd_hit) begin
            state_d = S_TIMEOUT;
          end
        end
        S_DONE, S_TIMEOUT: begin
          if (start) begin
            state_d  = S_RUN;
            zero_cnt = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ovf     <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (zero_cnt) begin
        ovf <= '0;
        for (int i = 0; i < NUM_CNT; i++) begin
          cnt_q[i] <= '0;
        end
      end else if (count_en) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (inc[i]) begin
            if (&cnt_q[i]) begin
              ovf[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
        end
      end
    end
  end

`ifdef PERF_EXEC_TIME_EN
  localparam logic [CNT_WIDTH-1:0] PERIOD = CNT_WIDTH'(CLK_PERIOD_PS);

  logic fin_q;

  // The frozen cycle count is only stable the cycle after the run ends, so the load trails by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_q     <= 1'b0;
      exec_time <= '0;
    end else begin
      fin_q <= (state_q == S_RUN) && ((state_d == S_DONE) || (state_d == S_TIMEOUT));
      if (zero_cnt) begin
        exec_time <= '0;
      end else if (fin_q) begin
        exec_time <= cnt_q[0] * PERIOD;
      end
    end
  end
`else
  assign exec_time = '0;
`endif

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next = cnt_q[i];
      end
    end
    if (rd_sel == SEL_W'(NUM_EVENTS + 2)) begin
      rd_next = exec_time;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign timeout = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - self-checking bench for perf_monitor across four parameter sets.
module tb_perf_monitor;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic          end_program;
  logic          retire;
  logic [NE-1:0] event_in;
  logic [2:0]    rd_sel;

  logic [63:0] rd0, rd1, rd3;
  logic [3:0]  rd2;
  logic        running0, done0, timeout0;
  logic        running1, done1, timeout1;
  logic        running2, done2, timeout2;
  logic        running3, done3, timeout3;
  logic [5:0]  ovf0, ovf1, ovf2, ovf3;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_v;
  logic [63:0] exp_exec;

  perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(64), .MAX_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .retire(retire), .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd0),
    .running(running0), .done(done0), .timeout(timeout0), .ovf(ovf0));

  perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(64), .MAX_CYCLES(10)) dut1 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .retire(retire), .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd1),
    .running(running1), .done(done1), .timeout(timeout1), .ovf(ovf1));

  perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(4), .MAX_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .retire(retire), .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd2),
    .running(running2), .done(done2), .timeout(timeout2), .ovf(ovf2));

  perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(64), .MAX_CYCLES(5)) dut3 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .retire(retire), .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd3),
    .running(running3), .done(done3), .timeout(timeout3), .ovf(ovf3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [2:0] sel, input logic [63:0] exp);
    rd_sel = sel;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({running0, done0, timeout0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {running0, done0, timeout0});
    end
    checks++;
    if (rd0 !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd_data: got %0d expected 0", rd0);
    end
    checks++;
    if (ovf0 !== 6'd0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 000000", ovf0);
    end
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_sel = 3'd0;
    repeat (7) tick();
    checks++;
    if (running0 !== 1'b1 || rd0 !== 64'd6) begin
      errors++;
      $display("FAIL pre_reset_run: got running=%b rd=%0d expected running=1 rd=6", running0, rd0);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({running0, done0, timeout0} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_flags: got %b expected 000", {running0, done0, timeout0});
    end
    checks++;
    if (rd0 !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_rd_data: got %0d expected 0", rd0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_end_program();
    logic [2:0]  sels [5];
    logic [63:0] exps [5];
    sels = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    exps = '{64'd6, 64'd6, 64'd0, 64'd6, 64'd0};
`ifdef PERF_EXEC_TIME_EN
    exp_exec = 64'd60000;
`else
    exp_exec = 64'd0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    retire = 1'b1;
    event_in = 4'b0010;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    checks++;
    if (done0 !== 1'b1 || running0 !== 1'b0) begin
      errors++;
      $display("FAIL end_done: got done=%b running=%b expected done=1 running=0", done0, running0);
    end
    tick();
    issue_read(3'd6, exp_exec);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (rd0 !== exp_v) begin
      errors++;
      $display("FAIL exec_time: got %0d expected %0d", rd0, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      issue_read(sels[i], exps[i]);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (rd0 !== exp_v) begin
        errors++;
        $display("FAIL frozen_sel%0d: got %0d expected %0d", sels[i], rd0, exp_v);
      end
    end
    retire = 1'b0;
    event_in = '0;
  endtask

  task automatic test_watchdog();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    checks++;
    if (done1 !== 1'b0 || running1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_end_ignored: got done=%b running=%b expected 0 0", done1, running1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (timeout1 !== 1'b0 || running1 !== 1'b1) begin
      errors++;
      $display("FAIL wd_before_limit: got timeout=%b running=%b expected 0 1", timeout1, running1);
    end
    tick();
    checks++;
    if (timeout1 !== 1'b1 || running1 !== 1'b0) begin
      errors++;
      $display("FAIL wd_timeout: got timeout=%b running=%b expected 1 0", timeout1, running1);
    end
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    issue_read(3'd0, 64'd10);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (rd1 !== exp_v) begin
      errors++;
      $display("FAIL wd_cycles: got %0d expected %0d", rd1, exp_v);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (timeout1 !== 1'b0 || running1 !== 1'b1) begin
      errors++;
      $display("FAIL wd_restart: got timeout=%b running=%b expected 0 1", timeout1, running1);
    end
    issue_read(3'd0, 64'd0);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (rd1 !== exp_v) begin
      errors++;
      $display("FAIL wd_restart_cycles: got %0d expected %0d", rd1, exp_v);
    end
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
  endtask

  task automatic test_saturation();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    event_in = 4'b0001;
    repeat (20) tick();
    checks++;
    if (ovf2 !== 6'b000101) begin
      errors++;
      $display("FAIL sat_ovf: got %b expected 000101", ovf2);
    end
    issue_read(3'd2, 64'd15);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({60'd0, rd2} !== exp_v) begin
      errors++;
      $display("FAIL sat_event0: got %0d expected %0d", rd2, exp_v);
    end
    issue_read(3'd0, 64'd15);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({60'd0, rd2} !== exp_v) begin
      errors++;
      $display("FAIL sat_cycles: got %0d expected %0d", rd2, exp_v);
    end
    event_in = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (ovf2 !== 6'd0 || running2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got ovf=%b running=%b expected 000000 0", ovf2, running2);
    end
    issue_read(3'd2, 64'd0);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({60'd0, rd2} !== exp_v) begin
      errors++;
      $display("FAIL sat_clear_event0: got %0d expected %0d", rd2, exp_v);
    end
  endtask

  task automatic test_same_edge();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    checks++;
    if (done3 !== 1'b1 || timeout3 !== 1'b0) begin
      errors++;
      $display("FAIL same_edge: got done=%b timeout=%b expected 1 0", done3, timeout3);
    end
    issue_read(3'd0, 64'd5);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (rd3 !== exp_v) begin
      errors++;
      $display("FAIL same_edge_cycles: got %0d expected %0d", rd3, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    end_program = 1'b0;
    retire = 1'b0;
    event_in = '0;
    rd_sel = '0;
    test_reset();
    test_end_program();
    test_watchdog();
    test_saturation();
    test_same_edge();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
